uart_rx_fifo: RTL

//   8N1 UART receiver for the UART_RXD board pin, running on the 12 MHz USB clock domain.

---
 rtl/uart_rx_fifo_pkg.sv | 25 ++
 rtl/uart_rx_fifo_if.sv | 34 +++
 rtl/uart_rx_fifo_buf.sv | 51 +++++
 rtl/uart_rx_fifo.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: receiver state encodings,
// byte type and the bit-period helper that the TX side also uses.
package uart_rx_fifo_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic [DATA_W-1:0] rx_byte_t;
    typedef logic [2:0]        rx_state_t;

    localparam rx_state_t RX_IDLE  = 3'd0;
    localparam rx_state_t RX_START = 3'd1;
    localparam rx_state_t RX_DATA  = 3'd2;
    localparam rx_state_t RX_STOP  = 3'd3;
    localparam rx_state_t RX_BRK   = 3'd4;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-side bundle: serial line in, byte stream out with valid/ready,
// plus the status pulses. The receiver uses the slave modport.
interface uart_rx_fifo_if;
    import uart_rx_fifo_pkg::*;

    logic     rxd;
    rx_byte_t rx_data;
    logic     rx_valid;
    logic     rx_ready;
    logic     frame_err;
    logic     overrun;
    logic     busy;

    modport slave (
        input  rxd,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport master (
        output rxd,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

endinterface

// File: rtl/uart_rx_fifo_buf.sv
// Show-ahead synchronous FIFO for received bytes; head is read combinationally
// from registered memory and pointers.
module uart_rx_fifo_buf #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  uart_rx_fifo_pkg::rx_byte_t push_data,
    output logic                       full,
    input  logic                       pop,
    output uart_rx_fifo_pkg::rx_byte_t head,
    output logic                       empty
);
    import uart_rx_fifo_pkg::*;

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    rx_byte_t    mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop synchroniser, oversampled bit timer with a
// three-sample majority vote, framing FSM and a small receive FIFO.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_fifo_if.slave rx
);
    import uart_rx_fifo_pkg::*;

    localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CW  = $clog2(CPB);
    localparam int unsigned MID = CPB / 2;

    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [1:0]    sync_vld;
    logic          armed;

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    rx_byte_t      shreg;
    logic          vote0;
    logic          vote1;
    logic          frame_err_q;
    logic          overrun_q;

    logic          fall;
    logic          at_dec;
    logic          at_last;
    logic          bit_val;
    logic          stop_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    rx_byte_t      fifo_head;

    // Edge detection stays disarmed after reset until the synchronised line
    // has been seen idle, so a line held low cannot fake a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            sync_vld <= '0;
            armed    <= 1'b0;
        end else begin
            rx_meta  <= rx.rxd;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign fall     = armed & rx_prev & ~rx_s;
    assign at_dec   = (cnt == CNT_DEC);
    assign at_last  = (cnt == CNT_LAST);
    assign bit_val  = maj3(vote0, vote1, rx_s);
    assign stop_ok  = (state == RX_STOP) & at_dec & bit_val;
    assign fifo_pop = rx.rx_ready & ~fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            vote0       <= 1'b1;
            vote1       <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= stop_ok & fifo_full & ~fifo_pop;
            if (state != RX_IDLE) begin
                cnt <= at_last ? '0 : cnt + 1'b1;
            end
            if (cnt == CNT_S0) begin
                vote0 <= rx_s;
            end
            if (cnt == CNT_S1) begin
                vote1 <= rx_s;
            end
            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (at_dec && bit_val) begin
                        state <= RX_IDLE;
                    end else if (at_last) begin
                        state   <= RX_DATA;
                        bit_idx <= '0;
                    end
                end
                RX_DATA: begin
                    if (at_dec) begin
                        shreg <= {bit_val, shreg[DATA_W-1:1]};
                    end
                    if (at_last) begin
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    // Stop bit is judged at mid-bit so the next start edge has half a bit of slack.
                    if (at_dec) begin
                        if (bit_val) begin
                            state <= RX_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= RX_BRK;
                        end
                    end
                end
                RX_BRK: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    uart_rx_fifo_buf #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (stop_ok),
        .push_data(shreg),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .empty    (fifo_empty)
    );

    assign rx.rx_data   = fifo_head;
    assign rx.rx_valid  = ~fifo_empty;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;
    assign rx.busy      = (state != RX_IDLE);

endmodule
